// File: rtl/gpi_filter_pkg.sv
// Shared types and limits for the GPI pad front-end: debounce FSM states and the
// minimum synchronizer depth.
package gpi_filter_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_QHI  = 2'b01,
    S_HIGH = 2'b10,
    S_QLO  = 2'b11
  } gpi_state_e;

endpackage

// File: rtl/gpi_sync.sv
// Generic N-stage flop synchronizer with synchronous active-low reset; the stages are
// also held at zero while en is low so a re-enabled input starts from a known state.
module gpi_sync
  import gpi_filter_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_MIN,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpi_debounce_filter.sv
// GPI pad front-end: synchronize, debounce and edge-detect pad DI, drive pad IE/STE.
// Optional sticky event flag is built when GPI_EVENT_LATCH_EN is defined.
module gpi_debounce_filter
  import gpi_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK_I,
  input  logic             RST_NI,
  input  logic             EN_I,
  input  logic [1:0]       STE_CFG_I,
  input  logic [CNT_W-1:0] DB_CYC_I,
  input  logic [1:0]       DI_I,
  output logic             IE_O,
  output logic [1:0]       STE_O,
  output logic             LEVEL_O,
  output logic             RISE_O,
  output logic             FALL_O,
  input  logic [1:0]       EVT_MASK_I,
  input  logic             EVT_CLR_I,
  output logic             EVT_O
);

  logic             s;
  gpi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             ie_q;
  logic [1:0]       ste_q;

  gpi_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_sync (
    .clk  (CLK_I),
    .rst_n(RST_NI),
    .en   (EN_I),
    .d    (DI_I[0]),
    .q    (s)
  );

  // cnt counts agreeing samples of the candidate level; the >= against the live threshold
  // lets a lowered DB_CYC_I finish a pending qualification immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!EN_I) begin
      state_d = S_LOW;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_LOW: begin
          if (s && (DB_CYC_I == '0)) begin
            state_d = S_HIGH;
            rise_d  = 1'b1;
          end else if (s) begin
            state_d = S_QHI;
            cnt_d   = CNT_W'(1);
          end
        end
        S_QHI: begin
          if (!s) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else if (cnt_q >= DB_CYC_I) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!s && (DB_CYC_I == '0)) begin
            state_d = S_LOW;
            fall_d  = 1'b1;
          end else if (!s) begin
            state_d = S_QLO;
            cnt_d   = CNT_W'(1);
          end
        end
        S_QLO: begin
          if (s) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else if (cnt_q >= DB_CYC_I) begin
            state_d = S_LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ie_q    <= 1'b0;
      ste_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ie_q    <= EN_I;
      ste_q   <= STE_CFG_I;
    end
  end

  assign IE_O    = ie_q;
  assign STE_O   = ste_q;
  assign LEVEL_O = (state_q == S_HIGH) || (state_q == S_QLO);
  assign RISE_O  = rise_q;
  assign FALL_O  = fall_q;

`ifdef GPI_EVENT_LATCH_EN
  logic evt_q;

  // A qualifying edge beats a simultaneous clear so no event is lost.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      evt_q <= 1'b0;
    end else if ((rise_q & EVT_MASK_I[0]) | (fall_q & EVT_MASK_I[1])) begin
      evt_q <= 1'b1;
    end else if (EVT_CLR_I) begin
      evt_q <= 1'b0;
    end
  end

  assign EVT_O = evt_q;

  logic unused_di;
  assign unused_di = DI_I[1];
`else
  assign EVT_O = 1'b0;

  logic unused_in;
  assign unused_in = ^{DI_I[1], EVT_MASK_I, EVT_CLR_I};
`endif

endmodule

// File: tb/tb_gpi_debounce_filter.sv
// Self-checking bench for gpi_debounce_filter: directed scenarios plus a randomized run
// compared cycle by cycle against a run-length debounce model.
module tb_gpi_debounce_filter;

  localparam int SS = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    ste;
  logic [CW-1:0] db;
  logic [1:0]    di;
  logic [1:0]    mask;
  logic          clr;
  logic          ie_o, level_o, rise_o, fall_o, evt_o;
  logic [1:0]    ste_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       pipe [SS];
  bit       m_level, m_rise, m_fall, m_ie, m_evt;
  bit [1:0] m_ste;
  int       m_run;

  gpi_debounce_filter #(
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .CLK_I     (clk),
    .RST_NI    (rst_n),
    .EN_I      (en),
    .STE_CFG_I (ste),
    .DB_CYC_I  (db),
    .DI_I      (di),
    .IE_O      (ie_o),
    .STE_O     (ste_o),
    .LEVEL_O   (level_o),
    .RISE_O    (rise_o),
    .FALL_O    (fall_o),
    .EVT_MASK_I(mask),
    .EVT_CLR_I (clr),
    .EVT_O     (evt_o)
  );

  always #5 clk = ~clk;

  logic [6:0] act;
  assign act = {level_o, rise_o, fall_o, ie_o, ste_o, evt_o};

  function automatic logic [6:0] exp_vec();
    return {m_level, m_rise, m_fall, m_ie, m_ste, m_evt};
  endfunction

  // Level flips once the delayed pad has disagreed with it for db+1 consecutive samples.
  task automatic model_edge();
    bit s, old_rise, old_fall;
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) pipe[i] = 1'b0;
      m_level = 0; m_run = 0; m_rise = 0; m_fall = 0; m_ie = 0; m_ste = 2'b00; m_evt = 0;
      return;
    end
    old_rise = m_rise;
    old_fall = m_fall;
`ifdef GPI_EVENT_LATCH_EN
    if ((old_rise && mask[0]) || (old_fall && mask[1])) m_evt = 1;
    else if (clr) m_evt = 0;
`else
    m_evt = 0;
`endif
    m_ie   = en;
    m_ste  = ste;
    m_rise = 0;
    m_fall = 0;
    if (!en) begin
      for (int i = 0; i < SS; i++) pipe[i] = 1'b0;
      m_level = 0;
      m_run   = 0;
    end else begin
      s = pipe[SS-1];
      for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = di[0];
      if (s != m_level) begin
        m_run++;
        if (m_run >= int'(db) + 1) begin
          m_level = s;
          m_run   = 0;
          if (s) m_rise = 1;
          else   m_fall = 1;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Steps until the requested pulse is seen; n = edges taken, -1 on timeout.
  task automatic wait_pulse(input bit want_rise, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if ((want_rise && rise_o) || (!want_rise && fall_o)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; ste = 2'b10; di = 2'b11; db = 4; mask = 2'b11; clr = 0;
    step();
    step();
    checks++;
    if (act !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", act, 7'b0);
    end
    rst_n = 1;
    di = 2'b00;
    step();
    checks++;
    if (rise_o !== 1'b0 || fall_o !== 1'b0 || level_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_cycle: got r%b f%b l%b want r0 f0 l0", rise_o, fall_o, level_o);
    end
    repeat (6) step();
  endtask

  task automatic test_latency();
    int n;
    db = 4; di = 2'b00; ste = 2'b01;
    repeat (8) step();
    di = 2'b01;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL latency_rise_model: got %b want %b", act, exp_vec());
      end
      if (rise_o) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL latency_rise_edges: got %0d want %0d", n, 7);
    end
    repeat (3) step();
    checks++;
    if (level_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_level_high: got %b want %b", level_o, 1'b1);
    end
    di = 2'b10;
    wait_pulse(1'b0, n);
    checks++;
    if (n != 7 || level_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_fall_edges: got %0d lvl %b want 7 lvl 0", n, level_o);
    end
  endtask

  task automatic test_glitch();
    int rises, falls;
    db = 4; di = 2'b00;
    repeat (8) step();
    rises = 0;
    for (int i = 0; i < 18; i++) begin
      di = (i < 3) ? 2'b01 : 2'b00;
      step();
      if (rise_o) rises++;
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_model: got %b want %b", act, exp_vec());
      end
    end
    checks++;
    if (rises != 0 || level_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_short_rejected: got rises=%0d lvl %b want 0 0", rises, level_o);
    end
    rises = 0; falls = 0;
    for (int i = 0; i < 25; i++) begin
      di = (i < 5) ? 2'b01 : 2'b00;
      step();
      if (rise_o) rises++;
      if (fall_o) falls++;
    end
    checks++;
    if (rises != 1 || falls != 1) begin
      errors++;
      $display("FAIL glitch_min_width: got rises=%0d falls=%0d want 1 1", rises, falls);
    end
  endtask

  task automatic test_db_zero();
    int toggles, pulses, hold, n;
    db = 0; di = 2'b00;
    repeat (5) step();
    toggles = 0; pulses = 0;
    for (int k = 0; k < 12; k++) begin
      di[0] = ~di[0];
      toggles++;
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        step();
        if (rise_o || fall_o) pulses++;
        checks++;
        if (act !== exp_vec()) begin
          errors++;
          $display("FAIL db0_model: got %b want %b", act, exp_vec());
        end
      end
    end
    repeat (5) begin
      step();
      if (rise_o || fall_o) pulses++;
    end
    checks++;
    if (pulses != toggles) begin
      errors++;
      $display("FAIL db0_pulse_count: got %0d want %0d", pulses, toggles);
    end
    di[0] = ~di[0];
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (level_o === di[0]) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL db0_latency: got %0d want %0d", n, 3);
    end
    di = 2'b00;
    repeat (6) step();
  endtask

  task automatic test_threshold_lower();
    db = 10; di = 2'b00;
    repeat (6) step();
    di = 2'b01;
    repeat (8) step();
    checks++;
    if (rise_o !== 1'b0 || level_o !== 1'b0) begin
      errors++;
      $display("FAIL thr_pending: got r%b l%b want r0 l0", rise_o, level_o);
    end
    db = 3;
    step();
    checks++;
    if (rise_o !== 1'b1 || level_o !== 1'b1 || act !== exp_vec()) begin
      errors++;
      $display("FAIL thr_lowered_rise: got %b want %b", act, exp_vec());
    end
    di = 2'b00;
    repeat (10) step();
  endtask

  task automatic test_enable();
    int n, pulses;
    db = 2; di = 2'b01;
    repeat (8) step();
    checks++;
    if (level_o !== 1'b1) begin
      errors++;
      $display("FAIL en_setup_high: got %b want %b", level_o, 1'b1);
    end
    en = 0;
    step();
    checks++;
    if (level_o !== 1'b0 || fall_o !== 1'b0 || ie_o !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_high: got l%b f%b ie%b want l0 f0 ie0", level_o, fall_o, ie_o);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      di[0] = ~di[0];
      step();
      if (rise_o || fall_o || level_o) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL en_off_quiet: got %0d active cycles want %0d", pulses, 0);
    end
    di = 2'b01;
    en = 1;
    wait_pulse(1'b1, n);
    checks++;
    if (n != 5 || ie_o !== 1'b1) begin
      errors++;
      $display("FAIL en_rise_after_enable: got %0d ie%b want 5 ie1", n, ie_o);
    end
    di = 2'b00;
    repeat (4) step();
    en = 0;
    step();
    checks++;
    if (level_o !== 1'b0 || fall_o !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_qualifying: got l%b f%b want l0 f0", level_o, fall_o);
    end
    en = 1;
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    db = 4; di = 2'b01;
    repeat (10) step();
    di = 2'b00;
    repeat (4) step();
    checks++;
    if (level_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_qlo: got %b want %b", level_o, 1'b1);
    end
    rst_n = 0;
    step();
    checks++;
    if (act !== 7'b0) begin
      errors++;
      $display("FAIL rstmid_cleared: got %b want %b", act, 7'b0);
    end
    rst_n = 1;
    step();
    checks++;
    if (rise_o !== 1'b0 || fall_o !== 1'b0 || act !== exp_vec()) begin
      errors++;
      $display("FAIL rstmid_after: got %b want %b", act, exp_vec());
    end
    repeat (6) step();
  endtask

  task automatic test_event();
`ifdef GPI_EVENT_LATCH_EN
    int n;
    db = 1; mask = 2'b10; clr = 1;
    step();
    clr = 0;
    di = 2'b01;
    wait_pulse(1'b1, n);
    step();
    checks++;
    if (n < 0 || evt_o !== 1'b0) begin
      errors++;
      $display("FAIL evt_rise_masked: got n=%0d evt %b want evt 0", n, evt_o);
    end
    di = 2'b00;
    wait_pulse(1'b0, n);
    step();
    checks++;
    if (n < 0 || evt_o !== 1'b1) begin
      errors++;
      $display("FAIL evt_fall_sets: got n=%0d evt %b want evt 1", n, evt_o);
    end
    clr = 1;
    step();
    clr = 0;
    checks++;
    if (evt_o !== 1'b0) begin
      errors++;
      $display("FAIL evt_clear: got %b want %b", evt_o, 1'b0);
    end
    di = 2'b01;
    wait_pulse(1'b1, n);
    di = 2'b00;
    wait_pulse(1'b0, n);
    clr = 1;
    step();
    clr = 0;
    checks++;
    if (n < 0 || evt_o !== 1'b1) begin
      errors++;
      $display("FAIL evt_set_beats_clear: got n=%0d evt %b want evt 1", n, evt_o);
    end
    en = 0;
    step();
    checks++;
    if (evt_o !== 1'b1) begin
      errors++;
      $display("FAIL evt_kept_when_disabled: got %b want %b", evt_o, 1'b1);
    end
    en = 1;
    repeat (4) step();
`else
    int hits;
    db = 0; hits = 0;
    for (int i = 0; i < 40; i++) begin
      di[0] = $urandom_range(0, 1);
      mask  = 2'($urandom);
      clr   = 1'($urandom);
      step();
      checks++;
      if (evt_o !== 1'b0) begin
        errors++;
        $display("FAIL evt_tied_low: got %b want %b", evt_o, 1'b0);
      end
    end
    clr = 0;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 4) db = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 25) di[0] = ~di[0];
      di[1] = 1'($urandom);
      en    = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      ste   = 2'($urandom);
      mask  = 2'($urandom);
      clr   = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b want %b", i, act, exp_vec());
      end
    end
    rst_n = 1; en = 1; clr = 0;
  endtask

  initial begin
    rst_n = 0; en = 0; ste = 2'b00; db = '0; di = 2'b00; mask = 2'b00; clr = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_db_zero();
    test_threshold_lower();
    test_enable();
    test_reset_mid();
    test_event();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/gpi_debounce_filter.md
# gpi_debounce_filter

Synchronizes, debounces and edge-detects the receiver output of a general-purpose input pad cell, producing a clean level and single-cycle rise/fall pulses for core logic. Sits directly downstream of the GPI pad (consumes its DI_O[1:0]) and drives the pad's IE_I and STE_I controls. It is the only path by which core logic reads a GPI pad.

## Interface
- SYNC_STAGES, 2, synchronizer depth; legal range ≥2.
- CNT_W, 16, debounce counter and threshold width.

- CLK_I  in  1  core clock.
- RST_NI  in  1  reset; one clock, synchronous, active-low.
- EN_I  in  1  block enable; drives pad input enable.
- STE_CFG_I  in  2  Schmitt-trigger configuration, forwarded to the pad.
- DB_CYC_I  in  CNT_W  debounce threshold; new level must persist DB_CYC_I+1 samples.
- DI_I  in  2  pad receiver output (pad DI_O); bit 0 used, bit 1 ignored (identical copy).
- IE_O  out  1  to pad IE_I.
- STE_O  out  2  to pad STE_I.
- LEVEL_O  out  1  debounced level.
- RISE_O  out  1  one-cycle pulse on qualified 0→1.
- FALL_O  out  1  one-cycle pulse on qualified 1→0.
- EVT_MASK_I  in  2  [0] latch rise, [1] latch fall.
- EVT_CLR_I  in  1  clears EVT_O.
- EVT_O  out  1  sticky event flag.

## Operation
- IE_O, STE_O: registered copies of EN_I, STE_CFG_I.
- Sync: DI_I[0] through SYNC_STAGES flops, reset 0 → `s`.
- FSM states S_LOW, S_QHI, S_HIGH, S_QLO; counter `cnt` (CNT_W bits).
  - S_LOW: s=1 and DB_CYC_I=0 → S_HIGH, RISE_O; s=1 otherwise → S_QHI, cnt=1.
  - S_QHI: s=0 → S_LOW, cnt=0 (glitch rejected, no pulse); cnt ≥ DB_CYC_I → S_HIGH, RISE_O; else cnt+1.
  - S_HIGH / S_QLO: mirror image, FALL_O on entry to S_LOW.
- `≥` compare against live DB_CYC_I: lowering the threshold mid-qualification completes at once; cnt never exceeds the threshold, so it never wraps.
- LEVEL_O = 1 in S_HIGH and S_QLO. RISE_O/FALL_O are registered and coincide with the first cycle of the new LEVEL_O. They are mutually exclusive.
- EN_I=0: sync flops, FSM and cnt are held at reset values. No pulses. LEVEL_O=0 without a FALL_O pulse, including when EN_I drops mid-qualification or while in S_HIGH.
- After EN_I rises, FSM starts in S_LOW. A pad already high yields a qualified RISE_O.

## Timing
- Reset values: IE_O=0, STE_O=2'b00, LEVEL_O=0, RISE_O=0, FALL_O=0, EVT_O=0, FSM=S_LOW, cnt=0.
- Latency, stable pad change to LEVEL_O/pulse: SYNC_STAGES+DB_CYC_I+1 clock edges.
- Minimum accepted pulse width: DB_CYC_I+1 cycles. Shorter pulses are suppressed.
- Reset asserted mid-qualification: all state cleared on that edge. No pulse in the reset cycle or the first cycle after it.

## Configuration
- GPI_EVENT_LATCH_EN defined: EVT_O sets on (RISE_O & EVT_MASK_I[0]) | (FALL_O & EVT_MASK_I[1]). EVT_CLR_I clears it one cycle later. Set wins over a simultaneous clear. EN_I=0 does not clear it.
- GPI_EVENT_LATCH_EN undefined: EVT_MASK_I and EVT_CLR_I are ignored; EVT_O is tied 0. Ports are present in both builds.

## Structure
- Package gpi_filter_pkg: FSM state enum, SYNC_STAGES_MIN=2 constant.
- Sub-module gpi_sync: generic N-stage synchronizer with sync active-low reset and hold-in-reset enable. Reused by other pad front-ends.

## Test plan
- DB_CYC_I=4, SYNC_STAGES=2, pad held high → RISE_O exactly 7 edges after change, LEVEL_O=1 thereafter. Release → FALL_O after 7 edges.
- DB_CYC_I=4, 3-cycle high glitch → no RISE_O, LEVEL_O stays 0. A 5-cycle pulse → RISE_O and FALL_O.
- DB_CYC_I=0 → level follows the pad with 3-edge latency; every toggle produces a pulse.
- Mid-S_QHI with cnt=6 of DB_CYC_I=10, DB_CYC_I lowered to 3 → RISE_O next edge.
- EN_I dropped in S_HIGH → LEVEL_O=0, no FALL_O, IE_O=0 next edge. RST_NI asserted in S_QLO → all outputs at reset values.
- GPI_EVENT_LATCH_EN, EVT_MASK_I=2'b10: rise → EVT_O stays 0; fall → EVT_O=1. Clear coincident with a new fall → EVT_O stays 1.
